// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM states, requester ids and
// the memory request record steered from the winning port.
package dmem_arb_pkg;

  // Widths of the request record; the arbiter's AW/DW must not exceed these.
  localparam int REQ_AW = 32;
  localparam int REQ_DW = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RR   = 2'd1,
    LOCK = 2'd2
  } arb_state_e;

  typedef enum logic {
    ID_CORE = 1'b0,
    ID_DMA  = 1'b1
  } req_id_e;

  typedef struct packed {
    logic              we;
    logic [REQ_AW-1:0] addr;
    logic [REQ_DW-1:0] wdata;
    logic [3:0]        be;
  } mem_req_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: req[0] is the core, req[1] the DMA. On a tie
// the requester that did not win last time is chosen.
module rr_pick2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  req_id_e    last,
  output req_id_e    winner,
  output logic       any
);

  // Pick the winner from the request pair and the previous owner.
  always_comb begin
    winner = ID_CORE;
    any    = 1'b0;
    case (req)
      2'b01: begin
        winner = ID_CORE;
        any    = 1'b1;
      end
      2'b10: begin
        winner = ID_DMA;
        any    = 1'b1;
      end
      2'b11: begin
        winner = (last == ID_DMA) ? ID_CORE : ID_DMA;
        any    = 1'b1;
      end
      default: begin
        winner = ID_CORE;
        any    = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the RV32I core (port 0) and a DMA/loader
// (port 1). One grant per cycle, round-robin on ties, optional DMA bus lock.
// Read data returns one cycle after the grant and is steered by an owner
// register. Optional lock timeout: define DMEM_ARB_LOCK_TIMEOUT_EN to bound
// the lock to LOCK_MAX grants while the core waits (sets sticky lock_err).
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int LOCK_MAX = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cancel_data_memory,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  input  logic [3:0]    c_be,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  input  logic [3:0]    d_be,
  input  logic          d_lock,
  output logic          c_gnt,
  output logic          d_gnt,
  output logic          c_rvalid,
  output logic          d_rvalid,
  output logic [DW-1:0] c_rdata,
  output logic [DW-1:0] d_rdata,
  output logic          core_stall,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [3:0]    mem_be,
  input  logic [DW-1:0] mem_rdata,
  output logic          lock_err
);

  arb_state_e state_r, next_state_s;
  req_id_e    last_r;
  req_id_e    pick_last_s;
  req_id_e    pick_winner_s;
  logic       pick_any_s;
  logic       c_eff_s;
  logic       c_gnt_s, d_gnt_s;
  logic       timeout_s;
  logic       owner_vld_r;
  req_id_e    owner_id_r;
  mem_req_t   win_req_s;

  assign c_eff_s = c_req & ~cancel_data_memory;

`ifdef DMEM_ARB_LOCK_TIMEOUT_EN
  localparam int CW = $clog2(LOCK_MAX + 1);
  logic [CW-1:0] lock_cnt_r;
  logic          lock_err_r;

  // A waiting core breaks the lock once LOCK_MAX locked beats have gone by.
  assign timeout_s = (state_r == LOCK) && (lock_cnt_r >= CW'(LOCK_MAX)) && c_eff_s;

  // Count locked DMA grants; cleared whenever the FSM is not staying in LOCK.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lock_cnt_r <= '0;
    end else if (next_state_s != LOCK) begin
      lock_cnt_r <= '0;
    end else if (d_gnt_s && d_lock && (lock_cnt_r < CW'(LOCK_MAX))) begin
      lock_cnt_r <= lock_cnt_r + CW'(1);
    end else begin
      lock_cnt_r <= lock_cnt_r;
    end
  end

  // Sticky record that a lock had to be broken.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lock_err_r <= 1'b0;
    end else begin
      lock_err_r <= lock_err_r | timeout_s;
    end
  end

  assign lock_err = lock_err_r;
`else
  assign timeout_s = 1'b0;
  assign lock_err  = 1'b0;
`endif

  // A broken lock hands the tie to the core by pretending the DMA won last.
  assign pick_last_s = timeout_s ? ID_DMA : last_r;

  rr_pick2 u_pick (
    .req    ({d_req, c_eff_s}),
    .last   (pick_last_s),
    .winner (pick_winner_s),
    .any    (pick_any_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next state and grants; the cycle d_lock drops is arbitrated as RR.
  always_comb begin
    next_state_s = state_r;
    c_gnt_s      = 1'b0;
    d_gnt_s      = 1'b0;
    case (state_r)
      IDLE: begin
        next_state_s = RR;
      end
      RR: begin
        c_gnt_s = pick_any_s && (pick_winner_s == ID_CORE);
        d_gnt_s = pick_any_s && (pick_winner_s == ID_DMA);
        if (d_gnt_s && d_lock) begin
          next_state_s = LOCK;
        end else begin
          next_state_s = RR;
        end
      end
      LOCK: begin
        if (timeout_s) begin
          c_gnt_s      = pick_any_s && (pick_winner_s == ID_CORE);
          d_gnt_s      = pick_any_s && (pick_winner_s == ID_DMA);
          next_state_s = RR;
        end else if (d_lock) begin
          d_gnt_s      = d_req;
          next_state_s = LOCK;
        end else begin
          c_gnt_s      = pick_any_s && (pick_winner_s == ID_CORE);
          d_gnt_s      = pick_any_s && (pick_winner_s == ID_DMA);
          next_state_s = RR;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Remember who was granted last for the round-robin tie break.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_r <= ID_DMA;
    end else if (c_gnt_s) begin
      last_r <= ID_CORE;
    end else if (d_gnt_s) begin
      last_r <= ID_DMA;
    end else begin
      last_r <= last_r;
    end
  end

  // Steer the winning request onto the memory port; all zero with no grant.
  always_comb begin
    win_req_s = '0;
    if (c_gnt_s) begin
      win_req_s.we    = c_we;
      win_req_s.addr  = REQ_AW'(c_addr);
      win_req_s.wdata = REQ_DW'(c_wdata);
      win_req_s.be    = c_be;
    end else if (d_gnt_s) begin
      win_req_s.we    = d_we;
      win_req_s.addr  = REQ_AW'(d_addr);
      win_req_s.wdata = REQ_DW'(d_wdata);
      win_req_s.be    = d_be;
    end else begin
      win_req_s = '0;
    end
  end

  // Owner pipeline: tag each read grant so its data returns to the right port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_vld_r <= 1'b0;
      owner_id_r  <= ID_CORE;
    end else begin
      owner_vld_r <= (c_gnt_s | d_gnt_s) & ~win_req_s.we;
      owner_id_r  <= d_gnt_s ? ID_DMA : ID_CORE;
    end
  end

  assign c_gnt      = c_gnt_s;
  assign d_gnt      = d_gnt_s;
  assign core_stall = c_eff_s & ~c_gnt_s;
  assign mem_en     = c_gnt_s | d_gnt_s;
  assign mem_we     = win_req_s.we;
  assign mem_addr   = AW'(win_req_s.addr);
  assign mem_wdata  = DW'(win_req_s.wdata);
  assign mem_be     = win_req_s.be;
  assign c_rvalid   = owner_vld_r & (owner_id_r == ID_CORE);
  assign d_rvalid   = owner_vld_r & (owner_id_r == ID_DMA);
  assign c_rdata    = mem_rdata;
  assign d_rdata    = mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: a table of per-cycle vectors for
// grants/stall/mem port, a read-return scoreboard, and hand-written reset
// and lock sequences (timeout behaviour when DMEM_ARB_LOCK_TIMEOUT_EN is set).
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cancel_data_memory = 1'b0;
  logic        c_req = 1'b0, c_we = 1'b0, d_req = 1'b0, d_we = 1'b0, d_lock = 1'b0;
  logic [31:0] c_addr = '0, d_addr = '0, c_wdata = '0, d_wdata = '0;
  logic [3:0]  c_be = '0, d_be = '0;
  logic        c_gnt, d_gnt, c_rvalid, d_rvalid, core_stall, mem_en, mem_we, lock_err;
  logic [31:0] c_rdata, d_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;

  dmem_arbiter #(.AW(32), .DW(32), .LOCK_MAX(8)) dut (
    .clk(clk), .rst(rst), .cancel_data_memory(cancel_data_memory),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_be(c_be),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_lock(d_lock), .c_gnt(c_gnt), .d_gnt(d_gnt), .c_rvalid(c_rvalid),
    .d_rvalid(d_rvalid), .c_rdata(c_rdata), .d_rdata(d_rdata),
    .core_stall(core_stall), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_rdata(mem_rdata), .lock_err(lock_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic exp_lock_err = 1'b0;

  // Memory behind the arbiter and the bench's own image of expected contents.
  logic [31:0] mem [256];
  logic [31:0] exp_mem [256];

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_rdata <= '0;
    end else begin
      if (mem_en && !mem_we) mem_rdata <= mem[mem_addr[9:2]];
      if (mem_en && mem_we)
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  typedef struct {
    logic        c_req, cancel, c_we;
    logic [31:0] c_addr, c_wdata;
    logic [3:0]  c_be;
    logic        d_req, d_we, d_lock;
    logic [31:0] d_addr, d_wdata;
    logic [3:0]  d_be;
    logic        e_cg, e_dg, e_st;
  } vec_t;

  typedef struct {
    logic        id;
    logic [31:0] data;
    int          cyc;
  } sb_t;

  sb_t sbq[$];
  sb_t mon_it;
  logic mon_ok;

  function automatic vec_t mk(input logic cr, input logic cx, input logic cw,
                              input logic [31:0] ca, input logic [31:0] cd,
                              input logic dr, input logic dw, input logic dl,
                              input logic [31:0] da, input logic [31:0] dd,
                              input logic ecg, input logic edg, input logic est);
    vec_t v;
    v.c_req = cr; v.cancel = cx; v.c_we = cw; v.c_addr = ca; v.c_wdata = cd; v.c_be = 4'hF;
    v.d_req = dr; v.d_we = dw; v.d_lock = dl; v.d_addr = da; v.d_wdata = dd; v.d_be = 4'hF;
    v.e_cg = ecg; v.e_dg = edg; v.e_st = est;
    return v;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    for (int b = 0; b < 4; b++)
      if (be[b]) exp_mem[a[9:2]][8*b +: 8] = d[8*b +: 8];
  endtask

  // Apply one vector, check at the falling edge, then advance to after the next rise.
  task automatic step(input vec_t v, input string nm, input bit push_en);
    logic [31:0] ea, ed;
    logic [3:0]  eb;
    logic        ew;
    cancel_data_memory = v.cancel;
    c_req = v.c_req; c_we = v.c_we; c_addr = v.c_addr; c_wdata = v.c_wdata; c_be = v.c_be;
    d_req = v.d_req; d_we = v.d_we; d_lock = v.d_lock; d_addr = v.d_addr; d_wdata = v.d_wdata; d_be = v.d_be;
    @(negedge clk);
    checks++;
    if ({c_gnt, d_gnt, core_stall} !== {v.e_cg, v.e_dg, v.e_st}) begin
      errors++;
      $display("FAIL %s gnt_stall got c_gnt=%b d_gnt=%b stall=%b exp %b %b %b",
               nm, c_gnt, d_gnt, core_stall, v.e_cg, v.e_dg, v.e_st);
    end
    ea = '0; ed = '0; eb = '0; ew = 1'b0;
    if (v.e_cg) begin ea = v.c_addr; ed = v.c_wdata; eb = v.c_be; ew = v.c_we; end
    else if (v.e_dg) begin ea = v.d_addr; ed = v.d_wdata; eb = v.d_be; ew = v.d_we; end
    checks++;
    if ({mem_en, mem_we, mem_addr, mem_wdata, mem_be} !== {v.e_cg | v.e_dg, ew, ea, ed, eb}) begin
      errors++;
      $display("FAIL %s mem_port got en=%b we=%b a=%h d=%h be=%h exp en=%b we=%b a=%h d=%h be=%h",
               nm, mem_en, mem_we, mem_addr, mem_wdata, mem_be, v.e_cg | v.e_dg, ew, ea, ed, eb);
    end
    checks++;
    if (lock_err !== exp_lock_err) begin
      errors++;
      $display("FAIL %s lock_err got %b exp %b", nm, lock_err, exp_lock_err);
    end
    if (v.e_cg | v.e_dg) begin
      if (ew) model_write(ea, ed, eb);
      else if (push_en) sbq.push_back('{id: v.e_dg, data: exp_mem[ea[9:2]], cyc: cyc + 1});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string nm);
    checks++;
    if ({c_gnt, d_gnt, c_rvalid, d_rvalid, mem_en, mem_we, lock_err, core_stall,
         mem_addr, mem_wdata, mem_be, c_rdata, d_rdata} !== '0) begin
      errors++;
      $display("FAIL %s reset_outputs got gnt=%b%b rv=%b%b en=%b we=%b le=%b st=%b a=%h d=%h be=%h rd=%h exp all 0",
               nm, c_gnt, d_gnt, c_rvalid, d_rvalid, mem_en, mem_we, lock_err, core_stall,
               mem_addr, mem_wdata, mem_be, c_rdata);
    end
  endtask

  // Read-return scoreboard: every rvalid must match the oldest expected read.
  always @(negedge clk) begin
    if (c_rvalid || d_rvalid) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL rvalid_spurious got c_rvalid=%b d_rvalid=%b exp none", c_rvalid, d_rvalid);
      end else begin
        mon_it = sbq.pop_front();
        if (mon_it.id == 1'b0)
          mon_ok = c_rvalid && !d_rvalid && (c_rdata === mon_it.data) && (cyc == mon_it.cyc);
        else
          mon_ok = d_rvalid && !c_rvalid && (d_rdata === mon_it.data) && (cyc == mon_it.cyc);
        if (!mon_ok) begin
          errors++;
          $display("FAIL rdata got c_rv=%b d_rv=%b c_rd=%h d_rd=%h cyc=%0d exp id=%0d data=%h cyc=%0d",
                   c_rvalid, d_rvalid, c_rdata, d_rdata, cyc, mon_it.id, mon_it.data, mon_it.cyc);
        end
      end
    end
  end

  vec_t vecs[22];
  vec_t tv;

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = {i[7:0], 8'h5A, ~i[7:0], 8'hC3};
    end
    mem[64] = 32'hDEAD_BEEF;
    for (int i = 0; i < 256; i++) exp_mem[i] = mem[i];

    //                c_req cx  cwe  c_addr        c_wdata        d_req dwe  dlk  d_addr        d_wdata        cg   dg   stall
    vecs[0]  = mk(1'b1,1'b0,1'b0,32'h0000_0100,32'h0,        1'b1,1'b0,1'b0,32'h0000_0200,32'h0,        1'b0,1'b0,1'b1);
    vecs[1]  = mk(1'b1,1'b0,1'b0,32'h0000_0100,32'h0,        1'b1,1'b0,1'b0,32'h0000_0200,32'h0,        1'b1,1'b0,1'b0);
    vecs[2]  = mk(1'b1,1'b0,1'b0,32'h0000_0100,32'h0,        1'b1,1'b0,1'b0,32'h0000_0200,32'h0,        1'b0,1'b1,1'b1);
    vecs[3]  = mk(1'b1,1'b0,1'b0,32'h0000_0100,32'h0,        1'b1,1'b0,1'b0,32'h0000_0200,32'h0,        1'b1,1'b0,1'b0);
    vecs[4]  = mk(1'b1,1'b0,1'b0,32'h0000_0100,32'h0,        1'b1,1'b0,1'b0,32'h0000_0200,32'h0,        1'b0,1'b1,1'b1);
    vecs[5]  = mk(1'b1,1'b0,1'b0,32'h0000_0100,32'h0,        1'b1,1'b0,1'b0,32'h0000_0200,32'h0,        1'b1,1'b0,1'b0);
    vecs[6]  = mk(1'b1,1'b0,1'b0,32'h0000_0100,32'h0,        1'b1,1'b0,1'b0,32'h0000_0200,32'h0,        1'b0,1'b1,1'b1);
    vecs[7]  = mk(1'b1,1'b0,1'b0,32'h0000_0100,32'h0,        1'b0,1'b0,1'b0,32'h0,        32'h0,        1'b1,1'b0,1'b0);
    vecs[8]  = mk(1'b0,1'b0,1'b0,32'h0,        32'h0,        1'b1,1'b0,1'b0,32'h0000_0204,32'h0,        1'b0,1'b1,1'b0);
    vecs[9]  = mk(1'b1,1'b1,1'b0,32'h0000_0100,32'h0,        1'b0,1'b0,1'b0,32'h0,        32'h0,        1'b0,1'b0,1'b0);
    vecs[10] = mk(1'b1,1'b1,1'b0,32'h0000_0100,32'h0,        1'b1,1'b1,1'b0,32'h0000_0300,32'hCAFE_F00D,1'b0,1'b1,1'b0);
    vecs[11] = mk(1'b1,1'b0,1'b1,32'h0000_0120,32'h1111_2222,1'b0,1'b0,1'b0,32'h0,        32'h0,        1'b1,1'b0,1'b0);
    vecs[11].c_be = 4'b0101;
    vecs[12] = mk(1'b1,1'b0,1'b0,32'h0000_0104,32'h0,        1'b1,1'b1,1'b1,32'h0000_0310,32'hAAAA_0001,1'b0,1'b1,1'b1);
    vecs[13] = mk(1'b1,1'b0,1'b0,32'h0000_0104,32'h0,        1'b1,1'b1,1'b1,32'h0000_0314,32'hAAAA_0002,1'b0,1'b1,1'b1);
    vecs[14] = mk(1'b1,1'b0,1'b0,32'h0000_0104,32'h0,        1'b1,1'b1,1'b1,32'h0000_0318,32'hAAAA_0003,1'b0,1'b1,1'b1);
    vecs[15] = mk(1'b1,1'b0,1'b0,32'h0000_0104,32'h0,        1'b1,1'b1,1'b1,32'h0000_031C,32'hAAAA_0004,1'b0,1'b1,1'b1);
    vecs[16] = mk(1'b1,1'b0,1'b0,32'h0000_0104,32'h0,        1'b1,1'b1,1'b0,32'h0000_0320,32'hAAAA_0005,1'b1,1'b0,1'b0);
    vecs[17] = mk(1'b0,1'b0,1'b0,32'h0,        32'h0,        1'b1,1'b0,1'b0,32'h0000_0310,32'h0,        1'b0,1'b1,1'b0);
    vecs[18] = mk(1'b1,1'b0,1'b0,32'h0000_0120,32'h0,        1'b0,1'b0,1'b0,32'h0,        32'h0,        1'b1,1'b0,1'b0);
    vecs[19] = mk(1'b1,1'b0,1'b0,32'h0000_031C,32'h0,        1'b1,1'b0,1'b0,32'h0000_0300,32'h0,        1'b0,1'b1,1'b1);
    vecs[20] = mk(1'b1,1'b0,1'b0,32'h0000_031C,32'h0,        1'b0,1'b0,1'b0,32'h0,        32'h0,        1'b1,1'b0,1'b0);
    vecs[21] = mk(1'b0,1'b0,1'b0,32'h0,        32'h0,        1'b0,1'b0,1'b0,32'h0,        32'h0,        1'b0,1'b0,1'b0);

    // Held in reset with a DMA request pending: everything must stay quiet.
    d_req = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("initial_reset");
    @(posedge clk);
    #1;
    rst = 1'b1;

    for (int i = 0; i < 22; i++) begin
      step(vecs[i], $sformatf("vec%0d", i), 1'b1);
    end

    // DMA holds the lock while the core keeps requesting (last owner = core).
    for (int k = 1; k <= 11; k++) begin
      tv = mk(1'b1, 1'b0, 1'b1, 32'h0000_0140, k, 1'b1, 1'b1, (k <= 10) ? 1'b1 : 1'b0,
              32'h0000_0380 + 32'(4 * k), 32'hB000_0000 + k, 1'b0, 1'b1, 1'b1);
`ifdef DMEM_ARB_LOCK_TIMEOUT_EN
      if (k == 9 || k == 11) begin tv.e_cg = 1'b1; tv.e_dg = 1'b0; tv.e_st = 1'b0; end
      if (k == 10) exp_lock_err = 1'b1;
`else
      if (k == 11) begin tv.e_cg = 1'b1; tv.e_dg = 1'b0; tv.e_st = 1'b0; end
`endif
      step(tv, $sformatf("lock_hold%0d", k), 1'b1);
    end
    step(vecs[21], "lock_err_sticky", 1'b1);

    // Reset arriving right after a core read grant drops that read's return.
    step(vecs[7], "pre_reset_read", 1'b0);
    rst = 1'b0;
    exp_lock_err = 1'b0;
    c_req = 1'b0; d_req = 1'b1; d_we = 1'b0; d_lock = 1'b0;
    @(negedge clk);
    check_reset_outputs("mid_read_reset");
    @(posedge clk);
    #1;
    rst = 1'b1;
    tv = vecs[7]; tv.e_cg = 1'b0; tv.e_st = 1'b1;
    step(tv, "post_reset_idle", 1'b1);
    step(vecs[7], "post_reset_first_gnt", 1'b1);
    step(vecs[21], "post_reset_drain0", 1'b1);
    step(vecs[21], "post_reset_drain1", 1'b1);

    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL rvalid_missing got %0d outstanding reads exp 0", sbq.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single-port data memory between two requesters: the RV32I core load/store port (port 0) and an external DMA/program-loader port (port 1). The block grants one access per cycle with round-robin fairness and an optional DMA burst lock. It steers 1-cycle-latency read data back to the owner and stalls the core while the core is not granted. It sits between `RV32I_wrapper`'s data-memory interface and the data memory macro.

## Interface
- `AW`, 32: byte address width; bits [1:0] ignored (word access)
- `DW`, 32: data width
- `LOCK_MAX`, 64: max consecutive locked DMA grants (used only with the macro)
- `clk` in 1: single clock, rising edge
- `rst` in 1: asynchronous, active-low reset
- `cancel_data_memory` in 1: masks core requests while high
- `c_req` / `d_req` in 1: core / DMA request, level, held until granted
- `c_we` / `d_we` in 1: write enable
- `c_addr` / `d_addr` in AW: byte address
- `c_wdata` / `d_wdata` in DW: write data
- `c_be` / `d_be` in 4: byte enables for writes
- `d_lock` in 1: DMA requests bus lock for consecutive beats
- `c_gnt` / `d_gnt` out 1: grant, same cycle as the accepted request
- `c_rvalid` / `d_rvalid` out 1: read data valid, one cycle after a read grant
- `c_rdata` / `d_rdata` out DW: read data, mirrors `mem_rdata`
- `core_stall` out 1: `c_req & ~cancel_data_memory & ~c_gnt`
- `mem_en`, `mem_we` out 1; `mem_addr` out AW; `mem_wdata` out DW; `mem_be` out 4: memory request port
- `mem_rdata` in DW: memory read data, valid the cycle after `mem_en & ~mem_we`
- `lock_err` out 1: sticky lock-timeout flag (0 when the macro is absent)

## Operation
- The effective core request is `c_req & ~cancel_data_memory`.
- FSM states: IDLE, RR (normal arbitration), LOCK (DMA owns the bus). Reset → IDLE. IDLE → RR on the first cycle out of reset.
- RR, single requester: that requester is granted.
- RR, both requesting: the requester other than `last` is granted. `last` updates on every grant. Reset value of `last` = DMA, so the core wins the first tie.
- RR → LOCK when the DMA is granted with `d_lock=1`. In LOCK, only the DMA is granted, and `core_stall` stays asserted if the core requests. LOCK → RR on the first cycle with `d_lock=0` (that cycle is still arbitrated as RR).
- The grant drives the mem port combinationally from the winner: `mem_en=gnt_any`, and `mem_addr`, `mem_we`, `mem_wdata`, `mem_be` come from the winner. With no grant, `mem_en=0` and the other fields are 0.
- Read return: the owner register captures {valid, id} on a read grant. Next cycle, `rvalid` pulses to that id only. `rdata` is driven to both ports, and only the `rvalid` qualifies it. Writes produce no `rvalid`.
- `cancel_data_memory` rising during a core read does not suppress that read's `rvalid`.

## Timing
- Grant latency: 0 cycles when uncontended. Worst case is 1 cycle in RR, and unbounded in LOCK without the macro.
- Read latency: `rvalid` exactly 1 cycle after `gnt`. Back-to-back grants are allowed every cycle.
- Reset values: all grants, `rvalid`, `mem_en`, `mem_we`, `lock_err` = 0; `mem_*`, `rdata` buses = 0; state IDLE; `last` = DMA; owner invalid; lock counter 0.
- In IDLE, nothing is granted, so the first grant can occur in the second cycle after reset deassertion.
- Reset asserted mid-read: the pending `rvalid` is discarded and not delivered after reset.

## Configuration
- `DMEM_ARB_LOCK_TIMEOUT_EN` defined:
  - A counter increments on each locked DMA grant and clears when leaving LOCK.
  - When it reaches `LOCK_MAX` while the core is requesting, the FSM is forced LOCK → RR, the core wins the next tie, and `lock_err` is set sticky until reset.
- Macro not defined: the counter and `lock_err` logic are absent, `lock_err` is tied to 0, and the lock is held indefinitely.

## Structure
- `dmem_arb_pkg`: `arb_state_e` {IDLE, RR, LOCK}, `req_id_e` {ID_CORE, ID_DMA}, and the `mem_req_t` struct {we, addr, wdata, be}.
- One sub-module, `rr_pick2`: a 2-way round-robin picker (inputs req[1:0] and last; output winner). The FSM, owner pipeline register and timeout counter stay in the top level.

## Test plan
- Core only: `c_req`, read at 0x100 holding 0xDEADBEEF → `c_gnt` in the same cycle, `c_rvalid` next cycle with `c_rdata`=0xDEADBEEF, `core_stall`=0.
- Simultaneous: both requesting reads on the first active cycle → core granted first, DMA next cycle; grants alternate C, D, C, D over 6 cycles; `core_stall` high on the DMA-granted cycles.
- Lock: DMA writes 4 beats with `d_lock`=1 while the core requests → 4 consecutive `d_gnt`, `core_stall`=1 throughout; core granted on the cycle `d_lock` drops or the one after.
- Cancel: `cancel_data_memory`=1 with `c_req`=1 → no `c_gnt`, `mem_en`=0, `core_stall`=0; DMA unaffected.
- Reset mid-read: assert `rst`=0 in the cycle after a core read grant → no `c_rvalid`; all outputs 0 during reset; first grant occurs in the second cycle after release.
- With `DMEM_ARB_LOCK_TIMEOUT_EN` and `LOCK_MAX`=8: DMA holds `d_lock` while the core requests → after 8 DMA grants the core is granted and `lock_err`=1, which stays 1 until reset.
